irm_nec_rx_fifo: RTL



---
 rtl/irm_pkg.sv | 56 +++++
 rtl/irm_sync_fifo.sv | 65 ++++++
 rtl/irm_nec_rx_fifo.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irm_pkg.sv
// Shared types and constants for the NEC IR receiver: decoder states,
// pulse windows in 10 us ticks, register map and bit positions.
package irm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_LOW,
        ST_LEAD_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_WAIT_IDLE
    } irm_state_t;

    localparam int TICK_HZ = 100000;
    localparam int DUR_W   = 11;
    typedef logic [DUR_W-1:0] dur_t;

    // Windows are inclusive and measured in ticks of the preceding level
    localparam dur_t DUR_MAX        = 11'd1200;
    localparam dur_t LEAD_LOW_MIN   = 11'd800;
    localparam dur_t LEAD_LOW_MAX   = 11'd1000;
    localparam dur_t LEAD_HIGH_MIN  = 11'd400;
    localparam dur_t LEAD_HIGH_MAX  = 11'd500;
    localparam dur_t RPT_HIGH_MIN   = 11'd180;
    localparam dur_t RPT_HIGH_MAX   = 11'd270;
    localparam dur_t BIT_LOW_MIN    = 11'd40;
    localparam dur_t BIT_LOW_MAX    = 11'd70;
    localparam dur_t BIT0_HIGH_MIN  = 11'd40;
    localparam dur_t BIT0_HIGH_MAX  = 11'd80;
    localparam dur_t BIT1_HIGH_MIN  = 11'd140;
    localparam dur_t BIT1_HIGH_MAX  = 11'd200;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_RSVD    = 2'd3;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_ERR_LSB   = 8;
    localparam int ST_HEAD_RPT  = 16;
    localparam int ST_OVF       = 17;
    localparam int ST_BUSY      = 18;

    localparam int CTRL_IRQ_EN    = 0;
    localparam int CTRL_CHECK_INV = 1;
    localparam int CTRL_REPEAT_EN = 2;
    localparam int CTRL_FLUSH     = 3;

    localparam logic [31:0] EMPTY_READ = 32'hDEADBEEF;
    localparam int          ENTRY_W    = 33;

    function automatic logic in_window(input dur_t d, input dur_t lo, input dur_t hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/irm_sync_fifo.sv
// Single-clock FIFO with flush; a push while full is dropped unless a pop
// frees the slot in the same cycle. Flush beats push and pop.
module irm_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~i_flush & ~o_empty;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/irm_nec_rx_fifo.sv
// NEC IR receiver: conditions the active-low IR line, decodes frames and
// repeat codes, and queues them behind a small Avalon-MM register file.
module irm_nec_rx_fifo
    import irm_pkg::*;
#(
    parameter int CLK_HZ            = 50000000,
    parameter int FIFO_DEPTH        = 8,
    parameter int GLITCH_CYCLES     = 4,
    parameter bit CHECK_INV_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        irq,
    input  logic        s_cs_n,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        ir
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GC_W  = $clog2(GLITCH_CYCLES + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [GC_W-1:0]  GC_LAST    = GC_W'(GLITCH_CYCLES - 1);

    logic              r_ir_meta;
    logic              r_ir_sync;
    logic              r_filt;
    logic              r_filt_d;
    logic [GC_W-1:0]   r_glitch_cnt;
    logic [DIV_W-1:0]  r_div;
    dur_t              r_dur;
    irm_state_t        r_state;
    logic [4:0]        r_bit_idx;
    logic [31:0]       r_code;
    logic              r_frame_evt;
    logic              r_repeat_evt;
    logic              r_fsm_err;
    logic [31:0]       r_last_code;
    logic              r_last_valid;
    logic [7:0]        r_err_cnt;
    logic              r_overflow;
    logic              r_irq_en;
    logic              r_check_inv;
    logic              r_repeat_en;
    logic              r_irq;

    logic              w_tick;
    logic              w_fall;
    logic              w_rise;
    logic              w_timeout;
    logic              w_bit0;
    logic              w_bit1;
    logic              w_inv_bad;
    logic              w_frame_push;
    logic              w_repeat_push;
    logic              w_push;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_sel;
    logic              w_wr_status;
    logic              w_wr_ctrl;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_clr_err;
    logic              w_pop;
    logic [31:0]       w_status;
    logic              w_unused_wdata;

    // Level changes are accepted only after GLITCH_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_meta    <= 1'b1;
            r_ir_sync    <= 1'b1;
            r_filt       <= 1'b1;
            r_filt_d     <= 1'b1;
            r_glitch_cnt <= '0;
        end else begin
            r_ir_meta <= ir;
            r_ir_sync <= r_ir_meta;
            r_filt_d  <= r_filt;
            if (r_ir_sync == r_filt) begin
                r_glitch_cnt <= '0;
            end else if (r_glitch_cnt == GC_LAST) begin
                r_filt       <= r_ir_sync;
                r_glitch_cnt <= '0;
            end else begin
                r_glitch_cnt <= r_glitch_cnt + 1'b1;
            end
        end
    end

    assign w_fall    = r_filt_d & ~r_filt;
    assign w_rise    = ~r_filt_d & r_filt;
    assign w_tick    = (r_div == '0);
    assign w_timeout = (r_dur == DUR_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= DIV_RELOAD;
            r_dur <= '0;
        end else begin
            r_div <= w_tick ? DIV_RELOAD : r_div - 1'b1;
            if (w_fall || w_rise) begin
                r_dur <= '0;
            end else if (w_tick && !w_timeout) begin
                r_dur <= r_dur + 1'b1;
            end
        end
    end

    assign w_bit0 = in_window(r_dur, BIT0_HIGH_MIN, BIT0_HIGH_MAX);
    assign w_bit1 = in_window(r_dur, BIT1_HIGH_MIN, BIT1_HIGH_MAX);

    // Decoder; r_dur holds the length of the level that just ended on an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_code       <= '0;
            r_frame_evt  <= 1'b0;
            r_repeat_evt <= 1'b0;
            r_fsm_err    <= 1'b0;
        end else begin
            r_frame_evt  <= 1'b0;
            r_repeat_evt <= 1'b0;
            r_fsm_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) r_state <= ST_LEAD_LOW;
                end
                ST_LEAD_LOW: begin
                    if (w_rise && in_window(r_dur, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
                        r_state <= ST_LEAD_HIGH;
                    end else if (w_rise || w_timeout) begin
                        r_fsm_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_LEAD_HIGH: begin
                    if (w_fall && in_window(r_dur, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                        r_bit_idx <= '0;
                        r_code    <= '0;
                        r_state   <= ST_BIT_LOW;
                    end else if (w_fall && in_window(r_dur, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
                        r_repeat_evt <= 1'b1;
                        r_state      <= ST_WAIT_IDLE;
                    end else if (w_fall || w_timeout) begin
                        r_fsm_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_BIT_LOW: begin
                    if (w_rise && in_window(r_dur, BIT_LOW_MIN, BIT_LOW_MAX)) begin
                        r_state <= ST_BIT_HIGH;
                    end else if (w_rise || w_timeout) begin
                        r_fsm_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_BIT_HIGH: begin
                    if (w_fall && (w_bit0 || w_bit1)) begin
                        r_code[r_bit_idx] <= w_bit1;
                        if (r_bit_idx == 5'd31) begin
                            r_frame_evt <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_state   <= ST_BIT_LOW;
                        end
                    end else if (w_fall || w_timeout) begin
                        r_fsm_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if ((r_filt && !w_rise && r_dur != '0) || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_sel       = ~s_cs_n;
    assign w_wr_status = w_sel & s_write & (s_address == ADDR_STATUS);
    assign w_wr_ctrl   = w_sel & s_write & (s_address == ADDR_CONTROL);
    assign w_flush     = w_wr_ctrl & s_writedata[CTRL_FLUSH];
    assign w_clr_ovf   = w_wr_status & s_writedata[ST_OVF];
    assign w_clr_err   = w_wr_status & s_writedata[ST_HEAD_RPT];
    assign w_pop       = w_sel & s_read & (s_address == ADDR_DATA) & ~w_empty;

    assign w_unused_wdata = ^{s_writedata[31:18], s_writedata[15:4]};

    assign w_inv_bad     = r_check_inv & (r_code[31:24] != ~r_code[23:16]);
    assign w_frame_push  = r_frame_evt & ~w_inv_bad;
    assign w_repeat_push = r_repeat_evt & r_repeat_en & r_last_valid;
    assign w_push        = w_frame_push | w_repeat_push;
    assign w_push_data   = w_frame_push ? {1'b0, r_code} : {1'b1, r_last_code};

    irm_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_code  <= '0;
            r_last_valid <= 1'b0;
            r_err_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_irq_en     <= 1'b0;
            r_check_inv  <= CHECK_INV_DEFAULT;
            r_repeat_en  <= 1'b1;
            r_irq        <= 1'b0;
        end else begin
            if (w_frame_push) begin
                r_last_code  <= r_code;
                r_last_valid <= 1'b1;
            end
            if (w_flush) begin
                r_last_valid <= 1'b0;
            end
            if (w_clr_err) begin
                r_err_cnt <= '0;
            end else if ((r_fsm_err || (r_frame_evt && w_inv_bad)) && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            // A dropped entry wins over a same-cycle clear so it is never missed
            if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_push && w_full && !w_pop && !w_flush) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_ctrl) begin
                r_irq_en    <= s_writedata[CTRL_IRQ_EN];
                r_check_inv <= s_writedata[CTRL_CHECK_INV];
                r_repeat_en <= s_writedata[CTRL_REPEAT_EN];
            end
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign irq = r_irq;

    always_comb begin
        w_status                        = '0;
        w_status[ST_COUNT_LSB +: 7]     = 7'(w_count);
        w_status[ST_ERR_LSB +: 8]       = r_err_cnt;
        w_status[ST_HEAD_RPT]           = ~w_empty & w_head[32];
        w_status[ST_OVF]                = r_overflow;
        w_status[ST_BUSY]               = (r_state != ST_IDLE);
    end

    always_comb begin
        s_readdata = '0;
        if (w_sel) begin
            case (s_address)
                ADDR_DATA:    s_readdata = w_empty ? EMPTY_READ : w_head[31:0];
                ADDR_STATUS:  s_readdata = w_status;
                ADDR_CONTROL: begin
                    s_readdata[CTRL_IRQ_EN]    = r_irq_en;
                    s_readdata[CTRL_CHECK_INV] = r_check_inv;
                    s_readdata[CTRL_REPEAT_EN] = r_repeat_en;
                end
                default:      s_readdata = '0;
            endcase
        end
    end

endmodule
